fsm_session_arbiter: RTL and testbench

- Shares one 2-bit symbol tracker (ports in/in_valid/out/out_valid; accepts at most 20 symbols per in_valid burst) among NREQ requesters.
- Grants one requester at a time, round-robin, and forwards its symbol session to the tracker.
- Inserts the idle gap the tracker needs between sessions so its length counter restarts.
- Routes tracker responses back, tagged with the owning requester's id.

---
 rtl/fsm_session_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_fsm_session_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_session_arbiter.sv
// fsm_session_arbiter
//
// Shares one 2-bit symbol tracker among NREQ requesters. One requester at a
// time is granted (round-robin) and its symbol session is forwarded to the
// tracker. A fixed idle gap is inserted after every session so the tracker's
// burst-length counter restarts. Tracker responses are registered and tagged
// with the id of the requester that owned the most recent session.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   req            per-requester session request
//   sym_in         requester i symbol on bits [2i+1:2i]
//   sym_valid      per-requester symbol valid
//   sym_last       per-requester last-symbol marker (qualified by sym_valid)
//   grant          one-hot grant, zero when no session is active
//   fsm_in         symbol to tracker
//   fsm_in_valid   symbol valid to tracker
//   fsm_out        tracker response data
//   fsm_out_valid  tracker response valid
//   rsp_valid      registered copy of fsm_out_valid
//   rsp_data       registered copy of fsm_out
//   rsp_id         owner of the response
//   busy           high while a session or its trailing gap is in progress
//   trunc_err      one-cycle pulse when a session hits MAX_LEN without sym_last

module fsm_session_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_LEN  = 20,
  parameter int IDLE_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        sym_in,
  input  logic [NREQ-1:0]          sym_valid,
  input  logic [NREQ-1:0]          sym_last,
  output logic [NREQ-1:0]          grant,
  output logic [1:0]               fsm_in,
  output logic                     fsm_in_valid,
  input  logic [1:0]               fsm_out,
  input  logic                     fsm_out_valid,
  output logic                     rsp_valid,
  output logic [1:0]               rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy,
  output logic                     trunc_err
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(IDLE_GAP + 1);

  localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_GAP - 1);
  localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [1:0]        fsm_in_reg, fsm_in_next;
  logic              fsm_in_valid_reg, fsm_in_valid_next;
  logic              busy_reg, busy_next;
  logic              trunc_err_reg, trunc_err_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   owner_reg, owner_next;
  logic              rsp_valid_reg;
  logic [1:0]        rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;

  // Per-requester symbol slices, then the owner's view of its own lane.
  logic [1:0] req_sym [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_sym
      assign req_sym[gi] = sym_in[2*gi+1:2*gi];
    end
  endgenerate

  logic [1:0] own_sym;
  logic       own_valid;
  logic       own_last;

  assign own_sym   = req_sym[owner_reg];
  assign own_valid = sym_valid[owner_reg];
  assign own_last  = sym_last[owner_reg];

  // Round-robin search: start one past the previous winner and wrap. The
  // last candidate (k == NREQ) is the previous winner itself, so a lone
  // requester is re-granted. Wrap is free because NREQ is a power of 2.
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = rr_ptr_reg + ID_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next        = state_reg;
    grant_next        = grant_reg;
    fsm_in_next       = fsm_in_reg;
    fsm_in_valid_next = 1'b0;
    trunc_err_next    = 1'b0;
    len_next          = len_reg;
    gap_cnt_next      = gap_cnt_reg;
    rr_ptr_next       = rr_ptr_reg;
    owner_next        = owner_reg;

    unique case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next         = '0;
          grant_next[win_id] = 1'b1;
          owner_next         = win_id;
          rr_ptr_next        = win_id;
          len_next           = '0;
          state_next         = STREAM;
        end
      end

      STREAM: begin
        if (own_valid) begin
          // The accepted symbol is forwarded even on the session's last edge.
          fsm_in_next       = own_sym;
          fsm_in_valid_next = 1'b1;
          len_next          = len_reg + LEN_W'(1);
          if (own_last || (len_reg == LAST_LEN)) begin
            trunc_err_next = !own_last;
            grant_next     = '0;
            gap_cnt_next   = GAP_INIT;
            state_next     = GAP;
          end
        end else begin
          // A stalled (or never-started) session ends without forwarding.
          grant_next   = '0;
          gap_cnt_next = GAP_INIT;
          state_next   = GAP;
        end
      end

      GAP: begin
        fsm_in_next = 2'b00;
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end

      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      fsm_in_reg       <= 2'b00;
      fsm_in_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      trunc_err_reg    <= 1'b0;
      len_reg          <= '0;
      gap_cnt_reg      <= '0;
      rr_ptr_reg       <= RR_INIT;
      owner_reg        <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= 2'b00;
      rsp_id_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      fsm_in_reg       <= fsm_in_next;
      fsm_in_valid_reg <= fsm_in_valid_next;
      busy_reg         <= busy_next;
      trunc_err_reg    <= trunc_err_next;
      len_reg          <= len_next;
      gap_cnt_reg      <= gap_cnt_next;
      rr_ptr_reg       <= rr_ptr_next;
      owner_reg        <= owner_next;
      // Responses are tagged with the current owner; owner only moves on a
      // grant, so late responses stay attributed to the last session.
      rsp_valid_reg    <= fsm_out_valid;
      rsp_data_reg     <= fsm_out;
      rsp_id_reg       <= owner_reg;
    end
  end

  assign grant        = grant_reg;
  assign fsm_in       = fsm_in_reg;
  assign fsm_in_valid = fsm_in_valid_reg;
  assign busy         = busy_reg;
  assign trunc_err    = trunc_err_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_id       = rsp_id_reg;

endmodule

// File: tb/tb_fsm_session_arbiter.sv
// Testbench for fsm_session_arbiter (NREQ=4, MAX_LEN=20, IDLE_GAP=2).
// Each vector drives the inputs for one clock and lists the outputs expected
// just after that edge.

module tb_fsm_session_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] sym_in;
  logic [3:0] sym_valid;
  logic [3:0] sym_last;
  logic [3:0] grant;
  logic [1:0] fsm_in;
  logic       fsm_in_valid;
  logic [1:0] fsm_out;
  logic       fsm_out_valid;
  logic       rsp_valid;
  logic [1:0] rsp_data;
  logic [1:0] rsp_id;
  logic       busy;
  logic       trunc_err;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  always #5 clk = ~clk;

  fsm_session_arbiter #(
    .NREQ(4),
    .MAX_LEN(20),
    .IDLE_GAP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sym_in(sym_in),
    .sym_valid(sym_valid),
    .sym_last(sym_last),
    .grant(grant),
    .fsm_in(fsm_in),
    .fsm_in_valid(fsm_in_valid),
    .fsm_out(fsm_out),
    .fsm_out_valid(fsm_out_valid),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy),
    .trunc_err(trunc_err)
  );

  typedef struct {
    int         tst;
    logic       rst;
    logic [3:0] req;
    logic [7:0] si;
    logic [3:0] sv;
    logic [3:0] sl;
    logic       ov;
    logic [1:0] od;
    logic [3:0] eg;
    logic [1:0] ef;
    logic       efv;
    logic       erv;
    logic [1:0] erd;
    logic [1:0] eri;
    logic       eb;
    logic       et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input int tst, input logic r, input logic [3:0] rq, input logic [7:0] si,
    input logic [3:0] sv, input logic [3:0] sl, input logic ov, input logic [1:0] od,
    input logic [3:0] eg, input logic [1:0] ef, input logic efv, input logic erv,
    input logic [1:0] erd, input logic [1:0] eri, input logic eb, input logic et);
    vec_t v;
    v.tst = tst; v.rst = r; v.req = rq; v.si = si; v.sv = sv; v.sl = sl;
    v.ov = ov; v.od = od; v.eg = eg; v.ef = ef; v.efv = efv; v.erv = erv;
    v.erd = erd; v.eri = eri; v.eb = eb; v.et = et;
    return v;
  endfunction

  function automatic vec_t rst_vec(input int tst);
    return mk(tst, 1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'b00,
              4'b0000, 2'b00, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst           = v.rst;
    req           = v.req;
    sym_in        = v.si;
    sym_valid     = v.sv;
    sym_last      = v.sl;
    fsm_out       = v.od;
    fsm_out_valid = v.ov;
    @(posedge clk);
    #1;
    chk("grant",        vec_no, {4'b0, grant},        {4'b0, v.eg});
    chk("fsm_in_valid", vec_no, {7'b0, fsm_in_valid}, {7'b0, v.efv});
    if (v.efv) chk("fsm_in", vec_no, {6'b0, fsm_in}, {6'b0, v.ef});
    chk("rsp_valid",    vec_no, {7'b0, rsp_valid},    {7'b0, v.erv});
    chk("rsp_data",     vec_no, {6'b0, rsp_data},     {6'b0, v.erd});
    chk("rsp_id",       vec_no, {6'b0, rsp_id},       {6'b0, v.eri});
    chk("busy",         vec_no, {7'b0, busy},         {7'b0, v.eb});
    chk("trunc_err",    vec_no, {7'b0, trunc_err},    {7'b0, v.et});
    $display("tx %0d test %0d rst=%b req=%b grant=%b fsm_in=%b/%b rsp=%b/%b/%0d busy=%b trunc=%b",
             vec_no, v.tst, v.rst, v.req, grant, fsm_in_valid, fsm_in, rsp_valid, rsp_data,
             rsp_id, busy, trunc_err);
    vec_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] eg;
    logic [1:0] iv;
    logic [1:0] prev;
    logic [1:0] kv;

    rst = 1'b1; req = '0; sym_in = '0; sym_valid = '0; sym_last = '0;
    fsm_out = '0; fsm_out_valid = 1'b0;

    // Test 1: single session from requester 0, response tagged id 0.
    vecs.push_back(rst_vec(1));
    vecs.push_back(mk(1, 0, 4'b0001, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h00, 4'b0001, 4'b0000, 0, 2'b00, 4'b0001, 2'b00, 1, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 0, 2'b00, 4'b0001, 2'b01, 1, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 0, 2'b00, 4'b0001, 2'b01, 1, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h03, 4'b0001, 4'b0001, 0, 2'b00, 4'b0000, 2'b11, 1, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1, 2'b10, 4'b0000, 2'b00, 0, 1, 2'b10, 2'd0, 1, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd0, 0, 0));
    vecs.push_back(mk(1, 0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd0, 0, 0));

    // Test 2: all requesting, one-symbol sessions, round-robin order.
    vecs.push_back(rst_vec(2));
    for (int i = 0; i < 4; i++) begin
      eg   = 4'(1 << i);
      iv   = 2'(i);
      prev = (i == 0) ? 2'd0 : 2'(i - 1);
      vecs.push_back(mk(2, 0, 4'b1111, 8'he4, 4'b1111, 4'b1111, 0, 2'b00, eg,      2'b00, 0, 0, 2'b00, prev, 1, 0));
      vecs.push_back(mk(2, 0, 4'b1111, 8'he4, 4'b1111, 4'b1111, 0, 2'b00, 4'b0000, iv,    1, 0, 2'b00, iv,   1, 0));
      vecs.push_back(mk(2, 0, 4'b1111, 8'he4, 4'b1111, 4'b1111, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, iv,   1, 0));
      vecs.push_back(mk(2, 0, 4'b1111, 8'he4, 4'b1111, 4'b1111, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, iv,   0, 0));
    end
    vecs.push_back(mk(2, 0, 4'b1111, 8'he4, 4'b1111, 4'b1111, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 2'b00, 2'd3, 1, 0));

    // Test 4: empty session from requester 1; rr_ptr must advance to 1.
    vecs.push_back(rst_vec(4));
    vecs.push_back(mk(4, 0, 4'b0010, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0010, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(4, 0, 4'b0110, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd1, 1, 0));
    vecs.push_back(mk(4, 0, 4'b0110, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd1, 1, 0));
    vecs.push_back(mk(4, 0, 4'b0110, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd1, 0, 0));
    vecs.push_back(mk(4, 0, 4'b0110, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0100, 2'b00, 0, 0, 2'b00, 2'd1, 1, 0));

    // Test 6: response during GAP after requester 3, requester 0 pending.
    vecs.push_back(rst_vec(6));
    vecs.push_back(mk(6, 0, 4'b1000, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b1000, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));
    vecs.push_back(mk(6, 0, 4'b0001, 8'hc0, 4'b1000, 4'b1000, 0, 2'b00, 4'b0000, 2'b11, 1, 0, 2'b00, 2'd3, 1, 0));
    vecs.push_back(mk(6, 0, 4'b0001, 8'h00, 4'b0000, 4'b0000, 1, 2'b01, 4'b0000, 2'b00, 0, 1, 2'b01, 2'd3, 1, 0));
    vecs.push_back(mk(6, 0, 4'b0001, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd3, 0, 0));
    vecs.push_back(mk(6, 0, 4'b0001, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 2'b00, 2'd3, 1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Test 3: requester 2 streams 25 symbols with no sym_last.
    apply(rst_vec(3));
    apply(mk(3, 0, 4'b1100, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0100, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));
    for (int k = 1; k <= 25; k++) begin
      kv = 2'(k);
      if (k <= 20)
        apply(mk(3, 0, 4'b1100, {2'b00, kv, 4'b0000}, 4'b0100, 4'b0000, 0, 2'b00,
                 (k < 20) ? 4'b0100 : 4'b0000, kv, 1, 0, 2'b00, 2'd2, 1, (k == 20)));
      else if (k == 21)
        apply(mk(3, 0, 4'b1100, {2'b00, kv, 4'b0000}, 4'b0100, 4'b0000, 0, 2'b00,
                 4'b0000, 2'b00, 0, 0, 2'b00, 2'd2, 1, 0));
      else if (k == 22)
        apply(mk(3, 0, 4'b1100, {2'b00, kv, 4'b0000}, 4'b0100, 4'b0000, 0, 2'b00,
                 4'b0000, 2'b00, 0, 0, 2'b00, 2'd2, 0, 0));
      else if (k == 23)
        apply(mk(3, 0, 4'b1100, {2'b00, kv, 4'b0000}, 4'b0100, 4'b0000, 0, 2'b00,
                 4'b1000, 2'b00, 0, 0, 2'b00, 2'd2, 1, 0));
      else
        apply(mk(3, 0, 4'b1100, {2'b00, kv, 4'b0000}, 4'b0100, 4'b0000, 0, 2'b00,
                 4'b0000, 2'b00, 0, 0, 2'b00, 2'd3, 1, 0));
    end

    // Test 5: reset asserted on the third symbol of a session.
    apply(rst_vec(5));
    apply(mk(5, 0, 4'b0001, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));
    apply(mk(5, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 0, 2'b00, 4'b0001, 2'b01, 1, 0, 2'b00, 2'd0, 1, 0));
    apply(mk(5, 0, 4'b0000, 8'h02, 4'b0001, 4'b0000, 0, 2'b00, 4'b0001, 2'b10, 1, 0, 2'b00, 2'd0, 1, 0));
    apply(mk(5, 1, 4'b0000, 8'h03, 4'b0001, 4'b0000, 1, 2'b11, 4'b0000, 2'b00, 0, 0, 2'b00, 2'd0, 0, 0));
    apply(mk(5, 0, 4'b0011, 8'h00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0001, 2'b00, 0, 0, 2'b00, 2'd0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
